vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Memory-side responder for the video fetch interface and the Z80 port into contended RAM.
- Serves video reads from the screen RAM (banks 5 and 7) and returns the fetched bytes.
- Arbitrates CPU accesses to that RAM: the CPU is stalled (clock-enable suppressed) while the video side signals contention, and video fetches always have priority.
- Sits between the video generator, the CPU clock/enable logic and the external synchronous screen RAM.

Parameters:
- RAM_AW, 15, screen RAM address width: bit 14 selects bank 5 (0) or bank 7 (1).
- ODD_CONTENDED, 1, 1 = 128K contention rules (C000-FFFF with an odd page is contended); 0 = 48K rules (only 4000-7FFF).

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  pixel clock enable, shared with the video generator.
- vA  in  13  video fetch address within the screen bank.
- vRd  in  1  video read request.
- vCn  in  1  video contention window; superset of vRd.
- vD  out  8  fetched byte to the video side.
- screenSel  in  1  0 = screen in bank 5, 1 = shadow screen in bank 7.
- page  in  3  RAM page mapped at C000-FFFF.
- cpuCe  in  1  raw CPU clock enable.
- cpuCeOut  out  1  gated CPU clock enable.
- mreqN, rdN, wrN  in  1 each  Z80 strobes, active low.
- cpuA  in  16  CPU address.
- cpuDo  in  8  CPU write data.
- cpuDi  out  8  CPU read data.
- cpuHit  out  1  the current CPU address maps into this RAM.
- ramA  out  RAM_AW  RAM address.
- ramDi  out  8  RAM write data.
- ramDo  in  8  RAM read data, valid one clock after ramA.
- ramWe  out  1  RAM write strobe.

Behaviour:
- Reset values: vD=00, cpuDi=FF, ramA=0, ramDi=00, ramWe=0, state=IDLE. cpuCeOut is forced to 0 while reset is low.
- Address map, cpuHit:
  - cpuHit=1 for cpuA[15:14]=01, mapped to {0, cpuA[13:0]}.
  - cpuHit=1 for cpuA[15:14]=11 with page=5, mapped to {0, cpuA[13:0]}.
  - cpuHit=1 for cpuA[15:14]=11 with page=7, mapped to {1, cpuA[13:0]}.
- Contended address: cpuA[15:14]=01, or (ODD_CONTENDED && cpuA[15:14]=11 && page[0]=1).
- Video path:
  - Every clock in which vRd=1: ramA={screenSel, 0, vA} and ramWe=0.
  - A vRd clock takes priority over any CPU RAM operation issued in that same clock.
  - vD captures ramDo on the clock after each vRd clock, so the total latency is 2 clocks. vD holds between fetches.
  - Requirement on the integrator: ce spacing must be at least 3 clocks so that vD is stable at the next ce.
- CPU FSM; states are evaluated every clock, with events qualified as noted:
  - IDLE:
    - A start is detected at cpuCe=1 with mreqN=0 and (rdN=0 or wrN=0) on a contended or hit address.
    - Start with vCn=1 -> STALL.
    - Start with vCn=0 and hit -> ACCESS.
    - Start with vCn=0, contended but not hit -> DONE.
    - Non-contended, non-hit addresses are ignored; the FSM stays in IDLE.
  - STALL:
    - cpuCeOut=0.
    - At a ce with vCn=0: hit -> ACCESS; otherwise -> DONE.
  - ACCESS:
    - cpuCeOut=0.
    - The first clock with vRd=0 issues the CPU address on ramA.
    - Write: ramDi=cpuDo and ramWe=1 for exactly that one clock, then -> DONE.
    - Read: capture ramDo into cpuDi on the next clock, then -> DONE.
    - If vRd rises after issue and before capture, the read is reissued.
  - DONE:
    - cpuCeOut=cpuCe.
    - On mreqN=1 -> IDLE.
    - No second access occurs while mreqN stays low.
- cpuCeOut=cpuCe in IDLE and DONE, and 0 in STALL and ACCESS.
- Simultaneous events:
  - A start and vCn rising in the same clock resolve to STALL.
  - screenSel changes take effect on the next video fetch. A fetch already issued is not corrupted.
- Reset low mid-access: ramWe drops immediately and the FSM returns to IDLE; no partial write follows.
- Non-hit read: cpuDi is left unchanged; cpuHit=0 tells the external data mux to ignore it.

Test Plan:
- Video read: screenSel=1, vA=0x0123, vRd pulse with ramDo model returning 0x5A -> ramA=0x4123; vD=0x5A two clocks after the vRd clock.
- Uncontended CPU read: cpuA=0x8000, mreqN=0 -> cpuHit=0, cpuCeOut follows cpuCe, no RAM activity.
- Contended CPU write with vCn=1 for 6 ce: cpuA=0x4000, cpuDo=0xA5 -> cpuCeOut=0 until vCn=0; then exactly one ramWe pulse with ramA=0x0000 and ramDi=0xA5.
- Paged read: page=7, cpuA=0xC010, RAM holds 0x3C -> ramA=0x4010; cpuDi=0x3C; FSM reaches DONE.
- Collision: CPU read issued while vRd rises the next clock -> the video fetch wins, the CPU read is reissued, both vD and cpuDi are correct.
- Contended non-hit: page=3, ODD_CONTENDED=1, cpuA=0xC000, vCn=1 -> stall released when vCn=0, no RAM access. Same access with ODD_CONTENDED=0 -> no stall.
- Reset pulse during ACCESS of a write -> ramWe=0 immediately, cpuDi=FF, state IDLE, RAM unchanged.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: screen-RAM responder for video fetches and contended Z80 accesses.
// Ports:
//   clock, reset           system clock, asynchronous active-low reset
//   ce                     pixel clock enable shared with the video generator
//   vA, vRd, vCn, vD       video fetch address, read request, contention window, fetched byte
//   screenSel, page        screen bank select (5/7), RAM page mapped at C000-FFFF
//   cpuCe, cpuCeOut        raw and gated CPU clock enable
//   mreqN, rdN, wrN        Z80 strobes (active low)
//   cpuA, cpuDo, cpuDi     CPU address, write data, read data
//   cpuHit                 CPU address maps into this RAM
//   ramA, ramDi, ramDo     synchronous screen RAM address, write data, read data (1 clock latency)
//   ramWe                  RAM write strobe
module vram_arbiter #(
    parameter int RAM_AW        = 15,
    parameter int ODD_CONTENDED = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ce,
    input  logic [12:0]       vA,
    input  logic              vRd,
    input  logic              vCn,
    output logic [7:0]        vD,
    input  logic              screenSel,
    input  logic [2:0]        page,
    input  logic              cpuCe,
    output logic              cpuCeOut,
    input  logic              mreqN,
    input  logic              rdN,
    input  logic              wrN,
    input  logic [15:0]       cpuA,
    input  logic [7:0]        cpuDo,
    output logic [7:0]        cpuDi,
    output logic              cpuHit,
    output logic [RAM_AW-1:0] ramA,
    output logic [7:0]        ramDi,
    input  logic [7:0]        ramDo,
    output logic              ramWe
);
    typedef enum logic [1:0] {IDLE, STALL, ACCESS, DONE} stateType;

    stateType    state, stateNext;
    logic [1:0]  acc, accNext;
    logic [1:0]  vPipe;
    logic        contended, start, issue, capture;
    logic [14:0] cpuRamA;

    assign cpuHit    = (cpuA[15:14] == 2'b01) || (cpuA[15:14] == 2'b11 && (page == 3'd5 || page == 3'd7));
    assign contended = (cpuA[15:14] == 2'b01) || (ODD_CONTENDED != 0 && cpuA[15:14] == 2'b11 && page[0]);
    // page 5 and the 4000 window land in bank 5; page 7 lands in bank 7
    assign cpuRamA   = {cpuA[15] & page[1], cpuA[13:0]};
    assign start     = cpuCe && !mreqN && (!rdN || !wrN) && (contended || cpuHit);
    assign cpuCeOut  = reset && cpuCe && (state == IDLE || state == DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            acc   <= 2'd0;
        end else begin
            state <= stateNext;
            acc   <= accNext;
        end
    end

    // acc tracks a CPU read in flight: 0 = not issued, 1 = address on RAM, 2 = data on ramDo
    always_comb begin
        stateNext = state;
        accNext   = acc;
        issue     = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE:   if (start) stateNext = vCn ? STALL : (cpuHit ? ACCESS : DONE);
            STALL:  if (ce && !vCn) stateNext = cpuHit ? ACCESS : DONE;
            ACCESS: begin
                if (acc == 2'd0) begin
                    if (!vRd) begin
                        issue     = 1'b1;
                        stateNext = !wrN ? DONE : ACCESS;
                        accNext   = !wrN ? 2'd0 : 2'd1;
                    end
                end else if (acc == 2'd1) begin
                    // a video fetch stepping in before capture forces a reissue
                    accNext = vRd ? 2'd0 : 2'd2;
                end else begin
                    capture   = 1'b1;
                    accNext   = 2'd0;
                    stateNext = DONE;
                end
            end
            DONE:   if (mreqN) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // vPipe[1] marks the clock where ramDo carries the byte addressed two clocks earlier
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vPipe <= 2'b00;
            vD    <= 8'h00;
            cpuDi <= 8'hFF;
            ramA  <= '0;
            ramDi <= 8'h00;
            ramWe <= 1'b0;
        end else begin
            vPipe <= {vPipe[0], vRd};
            ramWe <= issue && !wrN;
            if (vPipe[1]) vD <= ramDo;
            if (capture) cpuDi <= ramDo;
            if (vRd) begin
                ramA <= RAM_AW'({screenSel, 1'b0, vA});
            end else if (issue) begin
                ramA  <= RAM_AW'(cpuRamA);
                ramDi <= cpuDo;
            end
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed, table-driven bench for vram_arbiter with a synchronous RAM model.
module tb_vram_arbiter;
    logic        clock = 1'b0;
    logic        reset, ce, vRd, vCn, screenSel, cpuCe, mreqN, rdN, wrN;
    logic [12:0] vA;
    logic [2:0]  page;
    logic [15:0] cpuA;
    logic [7:0]  cpuDo, ramDo;
    logic [7:0]  vD, cpuDi, ramDi;
    logic        cpuCeOut, cpuHit, ramWe;
    logic [14:0] ramA;

    logic [7:0]  vD0, cpuDi0, ramDi0;
    logic        cpuCeOut0, cpuHit0, ramWe0;
    logic [14:0] ramA0;
    logic [7:0]  zeroDo = 8'h00;

    logic [7:0]  mem [0:32767];
    int          weCount = 0;
    int          cmpCount = 0;
    int          errCount = 0;
    int          weBefore;
    logic [1:0]  st, st0;

    localparam logic [1:0] S_IDLE = 2'd0, S_STALL = 2'd1, S_ACCESS = 2'd2, S_DONE = 2'd3;

    typedef struct {
        logic [15:0] a;
        logic [2:0]  pg;
        logic        hit;
    } hitVec;

    typedef struct {
        logic        sel;
        logic [12:0] a;
        logic [14:0] expA;
        logic [7:0]  d;
    } vidVec;

    hitVec hitTab [8];
    vidVec vidTab [4];

    vram_arbiter #(.RAM_AW(15), .ODD_CONTENDED(1)) dut (
        .clock(clock), .reset(reset), .ce(ce), .vA(vA), .vRd(vRd), .vCn(vCn), .vD(vD),
        .screenSel(screenSel), .page(page), .cpuCe(cpuCe), .cpuCeOut(cpuCeOut),
        .mreqN(mreqN), .rdN(rdN), .wrN(wrN), .cpuA(cpuA), .cpuDo(cpuDo), .cpuDi(cpuDi),
        .cpuHit(cpuHit), .ramA(ramA), .ramDi(ramDi), .ramDo(ramDo), .ramWe(ramWe)
    );

    vram_arbiter #(.RAM_AW(15), .ODD_CONTENDED(0)) dut0 (
        .clock(clock), .reset(reset), .ce(ce), .vA(vA), .vRd(vRd), .vCn(vCn), .vD(vD0),
        .screenSel(screenSel), .page(page), .cpuCe(cpuCe), .cpuCeOut(cpuCeOut0),
        .mreqN(mreqN), .rdN(rdN), .wrN(wrN), .cpuA(cpuA), .cpuDo(cpuDo), .cpuDi(cpuDi0),
        .cpuHit(cpuHit0), .ramA(ramA0), .ramDi(ramDi0), .ramDo(zeroDo), .ramWe(ramWe0)
    );

    assign st  = dut.state;
    assign st0 = dut0.state;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ramWe) begin
            mem[ramA] <= ramDi;
            weCount   <= weCount + 1;
        end
        ramDo <= mem[ramA];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmpCount++;
        if (act !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (st != S_DONE && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_reachDone"}, 32'(st), 32'(S_DONE));
    endtask

    initial begin
        hitTab[0] = '{16'h4000, 3'd0, 1'b1};
        hitTab[1] = '{16'h7FFF, 3'd0, 1'b1};
        hitTab[2] = '{16'h8000, 3'd5, 1'b0};
        hitTab[3] = '{16'h3FFF, 3'd5, 1'b0};
        hitTab[4] = '{16'hC000, 3'd5, 1'b1};
        hitTab[5] = '{16'hC000, 3'd7, 1'b1};
        hitTab[6] = '{16'hC000, 3'd3, 1'b0};
        hitTab[7] = '{16'hFFFF, 3'd0, 1'b0};
        vidTab[0] = '{1'b1, 13'h0123, 15'h4123, 8'h5A};
        vidTab[1] = '{1'b0, 13'h0123, 15'h0123, 8'h11};
        vidTab[2] = '{1'b0, 13'h1FFF, 15'h1FFF, 8'h22};
        vidTab[3] = '{1'b1, 13'h1FFF, 15'h5FFF, 8'h33};
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) mem[vidTab[i].expA] = vidTab[i].d;
        mem[15'h4010] = 8'h3C;
        mem[15'h0020] = 8'h99;
        mem[15'h0100] = 8'h77;

        reset = 1'b0; ce = 1'b0; vRd = 1'b0; vCn = 1'b0; screenSel = 1'b0; cpuCe = 1'b1;
        mreqN = 1'b1; rdN = 1'b1; wrN = 1'b1; vA = '0; page = '0; cpuA = '0; cpuDo = '0;
        repeat (3) tick();
        chk("rst_vD", 32'(vD), 32'h00);
        chk("rst_cpuDi", 32'(cpuDi), 32'hFF);
        chk("rst_ramA", 32'(ramA), 32'h0);
        chk("rst_ramWe", 32'(ramWe), 32'h0);
        chk("rst_cpuCeOut", 32'(cpuCeOut), 32'h0);
        chk("rst_state", 32'(st), 32'(S_IDLE));
        reset = 1'b1;
        tick();

        // address map, no strobes active
        for (int i = 0; i < 8; i++) begin
            cpuA = hitTab[i].a;
            page = hitTab[i].pg;
            #1;
            chk($sformatf("hit_%0d", i), 32'(cpuHit), 32'(hitTab[i].hit));
            chk($sformatf("idleCe_%0d", i), 32'(cpuCeOut), 32'h1);
        end

        // video fetches: address on the vRd clock, data two clocks later
        for (int i = 0; i < 4; i++) begin
            screenSel = vidTab[i].sel;
            vA = vidTab[i].a;
            vRd = 1'b1;
            tick();
            vRd = 1'b0;
            chk($sformatf("vidA_%0d", i), 32'(ramA), 32'(vidTab[i].expA));
            chk($sformatf("vidWe_%0d", i), 32'(ramWe), 32'h0);
            tick();
            tick();
            chk($sformatf("vidD_%0d", i), 32'(vD), 32'(vidTab[i].d));
        end
        tick();
        chk("vD_hold", 32'(vD), 32'h33);

        // uncontended, non-hit read
        weBefore = weCount;
        page = 3'd0; cpuA = 16'h8000; mreqN = 1'b0; rdN = 1'b0;
        repeat (3) tick();
        chk("unc_hit", 32'(cpuHit), 32'h0);
        chk("unc_ce", 32'(cpuCeOut), 32'h1);
        chk("unc_state", 32'(st), 32'(S_IDLE));
        chk("unc_ramA", 32'(ramA), 32'h5FFF);
        chk("unc_we", 32'(weCount - weBefore), 32'h0);
        mreqN = 1'b1; rdN = 1'b1;
        tick();

        // contended write held off by 6 contended ce
        weBefore = weCount;
        cpuA = 16'h4000; cpuDo = 8'hA5; vCn = 1'b1; mreqN = 1'b0; wrN = 1'b0;
        tick();
        chk("cw_stall", 32'(st), 32'(S_STALL));
        for (int i = 0; i < 6; i++) begin
            ce = 1'b1;
            tick();
            ce = 1'b0;
            chk($sformatf("cw_ce_%0d", i), 32'(cpuCeOut), 32'h0);
            tick();
            tick();
        end
        vCn = 1'b0; ce = 1'b1;
        tick();
        ce = 1'b0;
        chk("cw_access", 32'(st), 32'(S_ACCESS));
        chk("cw_accCe", 32'(cpuCeOut), 32'h0);
        tick();
        chk("cw_we", 32'(ramWe), 32'h1);
        chk("cw_ramA", 32'(ramA), 32'h0000);
        chk("cw_ramDi", 32'(ramDi), 32'hA5);
        chk("cw_doneCe", 32'(cpuCeOut), 32'h1);
        tick();
        chk("cw_weLow", 32'(ramWe), 32'h0);
        chk("cw_mem", 32'(mem[0]), 32'hA5);
        tick();
        tick();
        chk("cw_onePulse", 32'(weCount - weBefore), 32'h1);
        chk("cw_stayDone", 32'(st), 32'(S_DONE));
        mreqN = 1'b1; wrN = 1'b1;
        tick();
        chk("cw_idle", 32'(st), 32'(S_IDLE));

        // paged read from bank 7
        page = 3'd7; cpuA = 16'hC010; mreqN = 1'b0; rdN = 1'b0;
        tick();
        tick();
        chk("pg_ramA", 32'(ramA), 32'h4010);
        waitDone("pg");
        chk("pg_cpuDi", 32'(cpuDi), 32'h3C);
        mreqN = 1'b1; rdN = 1'b1;
        tick();

        // collision: video fetch lands right after the CPU issue
        page = 3'd0; cpuA = 16'h4020; mreqN = 1'b0; rdN = 1'b0;
        screenSel = 1'b0; vA = 13'h0123;
        tick();
        tick();
        chk("col_cpuA", 32'(ramA), 32'h0020);
        vRd = 1'b1;
        tick();
        vRd = 1'b0;
        chk("col_vidA", 32'(ramA), 32'h0123);
        waitDone("col");
        chk("col_cpuDi", 32'(cpuDi), 32'h99);
        chk("col_vD", 32'(vD), 32'h11);
        mreqN = 1'b1; rdN = 1'b1;
        tick();

        // contended, non-hit: 128K rules stall, 48K rules ignore
        weBefore = weCount;
        page = 3'd3; cpuA = 16'hC000; vCn = 1'b1; mreqN = 1'b0; rdN = 1'b0;
        tick();
        chk("nh_stall", 32'(cpuCeOut), 32'h0);
        chk("nh48_ce", 32'(cpuCeOut0), 32'h1);
        ce = 1'b1;
        tick();
        ce = 1'b0;
        chk("nh_stillStall", 32'(st), 32'(S_STALL));
        vCn = 1'b0; ce = 1'b1;
        tick();
        ce = 1'b0;
        chk("nh_done", 32'(st), 32'(S_DONE));
        chk("nh_ce", 32'(cpuCeOut), 32'h1);
        chk("nh_ramA", 32'(ramA), 32'h0020);
        chk("nh_we", 32'(weCount - weBefore), 32'h0);
        chk("nh48_state", 32'(st0), 32'(S_IDLE));
        mreqN = 1'b1; rdN = 1'b1;
        tick();

        // reset lands while a write strobe is out
        page = 3'd0; cpuA = 16'h4100; cpuDo = 8'hEE; mreqN = 1'b0; wrN = 1'b0;
        tick();
        chk("rw_access", 32'(st), 32'(S_ACCESS));
        tick();
        chk("rw_we", 32'(ramWe), 32'h1);
        reset = 1'b0;
        #1;
        chk("rw_weDrop", 32'(ramWe), 32'h0);
        chk("rw_cpuDi", 32'(cpuDi), 32'hFF);
        chk("rw_state", 32'(st), 32'(S_IDLE));
        chk("rw_ce", 32'(cpuCeOut), 32'h0);
        mreqN = 1'b1; wrN = 1'b1;
        tick();
        chk("rw_mem", 32'(mem[15'h0100]), 32'h77);
        reset = 1'b1;
        tick();
        chk("rw_idle", 32'(st), 32'(S_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end
endmodule
